tdm_mux_nx1: RTL and testbench
==============================

TDM_MUX_NX1 -- requirements
Module: tdm_mux_nx1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of each data channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of input channels (legal range 2..16).
REQ-003 The block SHALL have derived parameter SEL_W, default 2, equal to clog2(CHANNELS).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have port in_bus, input, CHANNELS*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port en, input, 1 bit, the global enable.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-009 The block SHALL have port select, input, SEL_W bits, the channel index used in manual mode.
REQ-010 The block SHALL have port dwell, input, 8 bits; each channel is held for dwell+1 cycles in scan mode.
REQ-011 The block SHALL have port out, output, WIDTH bits, the registered selected data.
REQ-012 The block SHALL have port out_valid, output, 1 bit, high when out holds a valid sample.
REQ-013 The block SHALL have port channel, output, SEL_W bits, the index of the channel currently driving out.
REQ-014 The block SHALL have port frame_done, output, 1 bit, a single-cycle pulse at the end of each scan frame.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, MANUAL and SCAN.
REQ-016 IDLE transitions: en=1 and mode=0 -> MANUAL; en=1 and mode=1 -> SCAN.
REQ-017 In MANUAL or SCAN, en=0 SHALL return the block to IDLE on the next edge.
REQ-018 In MANUAL or SCAN, a change of mode SHALL move directly to the other state on the next edge.
REQ-019 In IDLE, out and channel SHALL hold their last values, out_valid SHALL be 0, and the dwell counter SHALL be frozen.
REQ-020 MANUAL operation: out SHALL equal in_bus[select] and channel SHALL equal select, both one cycle after sampling; out_valid SHALL be 1.
REQ-021 MANUAL, select >= CHANNELS (possible when CHANNELS is not a power of 2): out SHALL be 0 and out_valid SHALL be 0; channel SHALL still load select.
REQ-022 SCAN entry (from IDLE or MANUAL): channel SHALL be 0 and the dwell counter SHALL be 0 on the first SCAN cycle; out SHALL be in_bus[0] registered.
REQ-023 SCAN operation: each cycle out SHALL be loaded with in_bus[channel], giving live data at 1-cycle latency; out_valid SHALL be 1.
REQ-024 SCAN stepping: the dwell counter SHALL increment each cycle; when it equals dwell, it SHALL clear and channel SHALL advance by 1.
REQ-025 SCAN wrap: channel SHALL advance from CHANNELS-1 to 0, and frame_done SHALL pulse for exactly the one cycle in which channel shows 0 after a wrap.
REQ-026 SCAN with dwell=0 SHALL advance channel every cycle.
REQ-027 A change of dwell mid-channel SHALL take effect on the next compare; if the counter already exceeds the new dwell, the block SHALL advance on the next cycle.
REQ-028 frame_done SHALL be 0 in IDLE and MANUAL, and no frame_done SHALL be generated on SCAN entry.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, out=0, out_valid=0, channel=0, frame_done=0 and dwell counter=0, regardless of clk.
REQ-030 Reset deassertion SHALL take effect on the first rising clk edge with rst_n=1; reset asserted mid-scan SHALL abort the frame with no frame_done.

Verification
REQ-031 Scenario 1 (reset): in_bus=16'h6A5C with en=1 and rst_n pulsed low mid-cycle -> all outputs 0 immediately; IDLE on release with en=0.
REQ-032 Scenario 2 (manual): WIDTH=4, CHANNELS=4, in_bus=16'h6A5C, mode=0, select 0,1,2,3 -> out C,5,A,6; channel 0..3; out_valid=1; 1-cycle latency each.
REQ-033 Scenario 3 (scan, dwell=2): mode=1 -> channel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; frame_done high only on the 13th cycle.
REQ-034 Scenario 4 (dwell=0): channel 0,1,2,3,0,1 on consecutive cycles; frame_done on the 5th cycle only.
REQ-035 Scenario 5 (enable/mode switching): en=0 during channel 2 -> out held, out_valid=0, counter frozen; en=1 then mode=0 then mode=1 -> scan restarts at channel 0.
REQ-036 Scenario 6 (non-power-of-2): CHANNELS=3, select=3 in manual mode -> out=0, out_valid=0; scan wraps 2 -> 0 with frame_done.

Source files
------------

// File: rtl/tdm_mux_nx1.sv
// N:1 time-division multiplexer with manual select and auto-scan modes.
// One output sample per clock, registered, with channel index and frame pulse.
module tdm_mux_nx1 #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [7:0]                dwell,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          channel,
  output logic                      frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [SEL_W-1:0] ch_d;
  logic [WIDTH-1:0] out_d;
  logic             valid_d;
  logic             fd_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      channel    <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      channel    <= ch_d;
      out        <= out_d;
      out_valid  <= valid_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_d  = IDLE;
    cnt_d    = cnt_q;
    ch_d     = channel;
    out_d    = out;
    valid_d  = 1'b0;
    fd_d     = 1'b0;
    sel_data = '0;
    sel_ok   = 1'b0;

    if (en) state_d = mode ? SCAN : MANUAL;

    unique case (state_d)
      MANUAL: begin
        ch_d  = select;
        cnt_d = '0;
      end
      SCAN: begin
        if (state_q != SCAN) begin
          ch_d  = '0;
          cnt_d = '0;
        end else if (cnt_q >= dwell) begin
          // >= so a dwell shrunk below the count advances at once
          cnt_d = '0;
          if (channel == LAST) begin
            ch_d = '0;
            fd_d = 1'b1;
          end else begin
            ch_d = channel + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase

    // Out-of-range selects leave sel_ok low
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_d == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end

    if (state_d != IDLE) begin
      out_d   = sel_ok ? sel_data : '0;
      valid_d = sel_ok;
    end
  end

endmodule

// File: tb/tb_tdm_mux_nx1.sv
// Directed scoreboard bench for tdm_mux_nx1.
// Runs a 4-channel and a 3-channel instance from shared stimulus.
module tb_tdm_mux_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_bus;
  logic [11:0] in_bus3;
  logic        en;
  logic        mode;
  logic [1:0]  select;
  logic [7:0]  dwell;

  logic [3:0]  out4;
  logic        v4;
  logic [1:0]  ch4;
  logic        fd4;
  logic [3:0]  out3;
  logic        v3;
  logic [1:0]  ch3;
  logic        fd3;

  typedef struct {
    logic [3:0] out;
    logic       v;
    logic [1:0] ch;
    logic       fd;
  } exp_t;

  exp_t       q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  bit         use3     = 1'b0;
  logic [3:0] last_out = '0;
  logic [1:0] last_ch  = '0;

  assign in_bus3 = in_bus[11:0];

  always #5 clk = ~clk;

  tdm_mux_nx1 #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .en(en),
    .mode(mode), .select(select), .dwell(dwell),
    .out(out4), .out_valid(v4), .channel(ch4), .frame_done(fd4)
  );

  tdm_mux_nx1 #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .en(en),
    .mode(mode), .select(select), .dwell(dwell),
    .out(out3), .out_valid(v3), .channel(ch3), .frame_done(fd3)
  );

  function automatic logic [3:0] nib(int k);
    logic [15:0] b;
    b = in_bus;
    return b[k*4 +: 4];
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [3:0] o, logic v, logic [1:0] c, logic f);
    exp_t e;
    e.out = o;
    e.v   = v;
    e.ch  = c;
    e.fd  = f;
    q.push_back(e);
    last_out = o;
    last_ch  = c;
  endtask

  task automatic push_idle();
    push(last_out, 1'b0, last_ch, 1'b0);
  endtask

  task automatic tick(string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      if (use3) begin
        chk({tag, "_out"}, 32'(out3), 32'(e.out));
        chk({tag, "_valid"}, 32'(v3), 32'(e.v));
        chk({tag, "_ch"}, 32'(ch3), 32'(e.ch));
        chk({tag, "_fd"}, 32'(fd3), 32'(e.fd));
      end else begin
        chk({tag, "_out"}, 32'(out4), 32'(e.out));
        chk({tag, "_valid"}, 32'(v4), 32'(e.v));
        chk({tag, "_ch"}, 32'(ch4), 32'(e.ch));
        chk({tag, "_fd"}, 32'(fd4), 32'(e.fd));
      end
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_out"}, 32'(out4), 32'd0);
    chk({tag, "_valid"}, 32'(v4), 32'd0);
    chk({tag, "_ch"}, 32'(ch4), 32'd0);
    chk({tag, "_fd"}, 32'(fd4), 32'd0);
    chk({tag, "_out3"}, 32'(out3), 32'd0);
    chk({tag, "_ch3"}, 32'(ch3), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    mode   = 1'b0;
    select = 2'd0;
    dwell  = 8'd0;
    in_bus = 16'h6A5C;
    #2;
    chk_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    push(4'h0, 1'b0, 2'd0, 1'b0);
    tick("idle_release");

    en   = 1'b1;
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      push(nib(s), 1'b1, 2'(s), 1'b0);
      tick("manual");
    end

    mode  = 1'b1;
    dwell = 8'd2;
    for (int i = 0; i < 15; i++) begin
      push(nib((i / 3) % 4), 1'b1, 2'((i / 3) % 4), i == 12);
      tick("scan_d2");
    end

    en = 1'b0;
    push_idle();
    tick("idle_hold");

    in_bus = 16'hF0E1;
    en     = 1'b1;
    dwell  = 8'd0;
    for (int i = 0; i < 6; i++) begin
      push(nib(i % 4), 1'b1, 2'(i % 4), i == 4);
      tick("scan_d0");
    end

    en = 1'b0;
    push_idle();
    tick("idle_d0");

    in_bus = 16'h6A5C;
    en     = 1'b1;
    dwell  = 8'd3;
    for (int i = 0; i < 10; i++) begin
      push(nib(i / 4), 1'b1, 2'(i / 4), 1'b0);
      tick("scan_d3");
    end

    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_idle();
      tick("en_off");
    end

    en = 1'b1;
    push(nib(0), 1'b1, 2'd0, 1'b0);
    tick("rescan");

    mode   = 1'b0;
    select = 2'd1;
    push(nib(1), 1'b1, 2'd1, 1'b0);
    tick("to_manual");

    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(nib(0), 1'b1, 2'd0, 1'b0);
      tick("to_scan");
    end

    dwell = 8'd1;
    push(nib(1), 1'b1, 2'd1, 1'b0);
    tick("dwell_shrink");
    push(nib(1), 1'b1, 2'd1, 1'b0);
    tick("dwell_new");

    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    @(negedge clk);
    rst_n    = 1'b1;
    en       = 1'b0;
    last_out = '0;
    last_ch  = '0;
    push_idle();
    tick("reset_idle");

    use3   = 1'b1;
    en     = 1'b1;
    mode   = 1'b0;
    select = 2'd1;
    push(nib(1), 1'b1, 2'd1, 1'b0);
    tick("c3_manual");
    select = 2'd3;
    push(4'h0, 1'b0, 2'd3, 1'b0);
    tick("c3_oob");

    mode  = 1'b1;
    dwell = 8'd0;
    for (int i = 0; i < 5; i++) begin
      push(nib(i % 3), 1'b1, 2'(i % 3), i == 3);
      tick("c3_scan");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
